// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial bit-pattern transmitter.
// Captures a pattern word on start and shifts it out MSB-first (bit Leff-1 first),
// one bit per clock on x. Frames repeat rpt+1 times with GAP idle cycles between
// them. A one-cycle done pulse follows the final frame. All outputs are registered.
//
// Optional feature macro: SEQ_GEN_PARITY_EN
//   When defined, each frame carries a trailing even-parity bit (XOR of the data bits)
//   and frame_end marks that parity bit instead of the last data bit.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      transmit request, honoured only while ready=1
//   pattern    W-bit data word, bit Leff-1 sent first
//   len        frame length in bits (0 -> 1, >W -> W)
//   rpt        extra repetitions, total frames = rpt+1
//   ready      high while idle
//   x          serial data bit
//   x_valid    x carries a frame bit
//   frame_end  marks the last bit of each frame
//   done       one-cycle pulse after the final frame
module seq_pattern_gen #(
  parameter int unsigned W     = 8,
  parameter int unsigned LW    = 4,
  parameter int unsigned CNT_W = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     pattern,
  input  logic [LW-1:0]    len,
  input  logic [CNT_W-1:0] rpt,
  output logic             ready,
  output logic             x,
  output logic             x_valid,
  output logic             frame_end,
  output logic             done
);

  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

  state_e           state_q, state_d;
  logic [W-1:0]     pat_q, pat_d;
  logic [LW-1:0]    leff_q, leff_d, leff_c;
  logic [LW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] frm_q, frm_d;   // frames still to send after the current one
  logic [GW-1:0]    gcnt_q, gcnt_d;
  logic             last_bit;
  logic             ready_d, x_d, x_valid_d, frame_end_d, done_d;
  logic [W-1:0]     shifted;
`ifdef SEQ_GEN_PARITY_EN
  logic             par_q, par_d;   // current SEND cycle is the parity bit
  logic [W-1:0]     par_mask;
  logic             par_bit;
`endif

  // Effective length, clamped at capture time.
  always_comb begin
    leff_c = len;
    if (len == '0) begin
      leff_c = LW'(1);
    end else if (len > LW'(W)) begin
      leff_c = LW'(W);
    end
  end

`ifdef SEQ_GEN_PARITY_EN
  assign last_bit = par_q;
`else
  assign last_bit = (idx_q == '0);
`endif

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      pat_q     <= '0;
      leff_q    <= '0;
      idx_q     <= '0;
      frm_q     <= '0;
      gcnt_q    <= '0;
      ready     <= 1'b1;
      x         <= 1'b0;
      x_valid   <= 1'b0;
      frame_end <= 1'b0;
      done      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      leff_q    <= leff_d;
      idx_q     <= idx_d;
      frm_q     <= frm_d;
      gcnt_q    <= gcnt_d;
      ready     <= ready_d;
      x         <= x_d;
      x_valid   <= x_valid_d;
      frame_end <= frame_end_d;
      done      <= done_d;
`ifdef SEQ_GEN_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    leff_d  = leff_q;
    idx_d   = idx_q;
    frm_d   = frm_q;
    gcnt_d  = gcnt_q;
`ifdef SEQ_GEN_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSend;
          pat_d   = pattern;
          leff_d  = leff_c;
          idx_d   = leff_c - LW'(1);
          frm_d   = rpt;
`ifdef SEQ_GEN_PARITY_EN
          par_d   = 1'b0;
`endif
        end
      end
      StSend: begin
        if (!last_bit) begin
`ifdef SEQ_GEN_PARITY_EN
          if (idx_q == '0) begin
            par_d = 1'b1;
          end else begin
            idx_d = idx_q - LW'(1);
          end
`else
          idx_d = idx_q - LW'(1);
`endif
        end else begin
`ifdef SEQ_GEN_PARITY_EN
          par_d = 1'b0;
`endif
          idx_d = leff_q - LW'(1);
          // Count remaining frames down rather than up so rpt at max never wraps.
          if (frm_q != '0) begin
            frm_d = frm_q - CNT_W'(1);
            if (GAP > 0) begin
              state_d = StGap;
              gcnt_d  = GW'(GAP - 1);
            end
          end else begin
            state_d = StDone;
          end
        end
      end
      StGap: begin
        if (gcnt_q == '0) begin
          state_d = StSend;
        end else begin
          gcnt_d = gcnt_q - GW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Output decode from the next state, so the registered outputs line up with state_q.
  always_comb begin
    shifted     = pat_d >> idx_d;
    ready_d     = (state_d == StIdle);
    x_valid_d   = (state_d == StSend);
    done_d      = (state_d == StDone);
`ifdef SEQ_GEN_PARITY_EN
    // Shifting by W yields 0, so the mask becomes all ones for Leff == W.
    par_mask    = (W'(1) << leff_d) - W'(1);
    par_bit     = ^(pat_d & par_mask);
    x_d         = x_valid_d & (par_d ? par_bit : shifted[0]);
    frame_end_d = x_valid_d & par_d;
`else
    x_d         = x_valid_d & shifted[0];
    frame_end_d = x_valid_d & (idx_d == '0);
`endif
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Randomized self-checking bench for seq_pattern_gen. Two instances (GAP=0 and GAP=2)
// share stimulus; each is compared cycle by cycle against an expected output stream
// built from the frame rules.
module tb_seq_pattern_gen;

`ifdef SEQ_GEN_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  typedef logic [4:0] vq_t[$];
  // Output vector layout: {ready, x, x_valid, frame_end, done}
  localparam logic [4:0] IdleVec = 5'b10000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] rpt = '0;
  logic       ready0, x0, xv0, fe0, done0;
  logic       ready1, x1, xv1, fe1, done1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_pattern_gen #(.W(8), .LW(4), .CNT_W(4), .GAP(0)) u_dut0 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .rpt       (rpt),
    .ready     (ready0),
    .x         (x0),
    .x_valid   (xv0),
    .frame_end (fe0),
    .done      (done0)
  );

  seq_pattern_gen #(.W(8), .LW(4), .CNT_W(4), .GAP(2)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .pattern   (pattern),
    .len       (len),
    .rpt       (rpt),
    .ready     (ready1),
    .x         (x1),
    .x_valid   (xv1),
    .frame_end (fe1),
    .done      (done1)
  );

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b ({ready,x,x_valid,frame_end,done})",
               tag, got, exp);
    end
  endtask

  // Expected per-cycle output stream, starting with the cycle after acceptance.
  task automatic build(input int gap, input logic [7:0] p, input logic [3:0] l,
                       input logic [3:0] r, output vq_t q);
    int leff;
    int ones;
    q = {};
    leff = (l == 0) ? 1 : ((l > 8) ? 8 : int'(l));
    for (int f = 0; f <= int'(r); f++) begin
      ones = 0;
      for (int b = leff - 1; b >= 0; b--) begin
        ones += int'(p[b]);
        q.push_back({1'b0, p[b], 1'b1, (b == 0) && !Par, 1'b0});
      end
      if (Par) q.push_back({1'b0, ones[0], 1'b1, 1'b1, 1'b0});
      if (f < int'(r)) begin
        for (int g = 0; g < gap; g++) q.push_back(5'b00000);
      end
    end
    q.push_back(5'b00001);
  endtask

  // One transaction; junk=1 pulses random start/inputs while both instances are busy.
  task automatic run_txn(input string name, input logic [7:0] p, input logic [3:0] l,
                         input logic [3:0] r, input bit junk);
    vq_t e0, e1;
    int  n;
    build(0, p, l, r, e0);
    build(2, p, l, r, e1);
    n = ((e0.size() > e1.size()) ? e0.size() : e1.size()) + 1;
    pattern = p;
    len     = l;
    rpt     = r;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    // Post-capture input changes must not affect the frame in flight.
    pattern = 8'($urandom);
    len     = 4'($urandom);
    rpt     = 4'($urandom);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s g0 c%0d", name, i), {ready0, x0, xv0, fe0, done0},
            (i < e0.size()) ? e0[i] : IdleVec);
      check($sformatf("%s g2 c%0d", name, i), {ready1, x1, xv1, fe1, done1},
            (i < e1.size()) ? e1[i] : IdleVec);
      start = junk && (i < e0.size() - 1) && ($urandom_range(0, 1) == 1);
      if (start) begin
        pattern = 8'($urandom);
        len     = 4'($urandom);
        rpt     = 4'($urandom);
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check({name, " g0"}, {ready0, x0, xv0, fe0, done0}, IdleVec);
    check({name, " g2"}, {ready1, x1, xv1, fe1, done1}, IdleVec);
  endtask

  initial begin
    vq_t e0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    run_txn("basic", 8'b0000_1101, 4'd4, 4'd0, 1'b0);
    run_txn("rpt2", 8'b0000_1101, 4'd4, 4'd2, 1'b0);
    run_txn("rpt1", 8'b0000_1101, 4'd4, 4'd1, 1'b0);
    run_txn("len0", 8'b1010_0111, 4'd0, 4'd0, 1'b0);
    run_txn("len12", 8'b1011_0010, 4'd12, 4'd0, 1'b0);
    run_txn("ign_start", 8'b0000_1101, 4'd4, 4'd1, 1'b1);
    run_txn("rptmax", 8'b0110_1001, 4'd3, 4'd15, 1'b0);

    // Reset on the second bit aborts the frame without frame_end or done.
    build(0, 8'b0000_1101, 4'd4, 4'd0, e0);
    pattern = 8'b0000_1101;
    len     = 4'd4;
    rpt     = 4'd0;
    start   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("midrst bit1 g0", {ready0, x0, xv0, fe0, done0}, e0[0]);
    @(negedge clk);
    check("midrst bit2 g0", {ready0, x0, xv0, fe0, done0}, e0[1]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst c0");
    @(negedge clk);
    check_idle("midrst c1");
    run_txn("after_rst", 8'b0000_1101, 4'd4, 4'd0, 1'b0);

    // rst and start together: rst wins.
    start = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check_idle("rst_start c0");
    @(negedge clk);
    check_idle("rst_start c1");

    for (int t = 0; t < 40; t++) begin
      run_txn($sformatf("rand%0d", t), 8'($urandom), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 4)), $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
